// File: rtl/mem_pkg.sv
// Shared widths and FSM encoding for the memory access controller.
package mem_pkg;

    localparam int unsigned ADDR_W         = 9;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned MAX_BURST_LOG2 = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t RD_ISSUE = 2'd1;
    localparam state_t RD_CAP   = 2'd2;
    localparam state_t WR       = 2'd3;

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the 512 x 32 synchronous RAM: sequences single and
// short-burst loads/stores, owns MAR/MDR and absorbs the one-cycle read latency.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W         = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W         = mem_pkg::DATA_W,
    parameter int unsigned MAX_BURST_LOG2 = mem_pkg::MAX_BURST_LOG2
) (
    input  logic                      Clock,
    input  logic                      Clear,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [MAX_BURST_LOG2-1:0] req_len_m1,
    input  logic [DATA_W-1:0]         wdata,
    output logic                      wdata_ready,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rdata_valid,
    output logic                      done,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);
    import mem_pkg::*;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         mar_q, mar_d;
    logic [MAX_BURST_LOG2-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]         mdr_q, mdr_d;
    logic                      rvalid_q, rvalid_d;
    logic                      done_q, done_d;

    // Next-state logic: accept in IDLE, two cycles per read word, one per write word.
    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        cnt_d    = cnt_q;
        mdr_d    = mdr_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mar_d   = req_addr;
                    cnt_d   = req_len_m1;
                    state_d = req_we ? WR : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                // RAM output is registered: the word addressed in RD_ISSUE is valid now.
                mdr_d    = mem_rdata;
                rvalid_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    mar_d   = mar_q + ADDR_W'(1);
                    cnt_d   = cnt_q - MAX_BURST_LOG2'(1);
                    state_d = RD_ISSUE;
                end
            end
            WR: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    mar_d = mar_q + ADDR_W'(1);
                    cnt_d = cnt_q - MAX_BURST_LOG2'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; Clear abandons any in-flight burst.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q  <= IDLE;
            mar_q    <= '0;
            cnt_q    <= '0;
            mdr_q    <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            cnt_q    <= cnt_d;
            mdr_q    <= mdr_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    // RAM strobes decode straight from state so they drop the instant Clear asserts.
    assign req_ready   = (state_q == IDLE);
    assign mem_read    = (state_q == RD_ISSUE);
    assign mem_write   = (state_q == WR);
    assign wdata_ready = mem_write;
    assign mem_addr    = mar_q;
    assign mem_wdata   = wdata;
    assign rdata       = mdr_q;
    assign rdata_valid = rvalid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 512 x 32 registered-read RAM.
module tb_mem_access_ctrl;

    logic        Clock;
    logic        Clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [1:0]  req_len_m1;
    logic [31:0] wdata;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // RAM model plus a bench-side preload port
    logic [31:0] ram [0:511];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .MAX_BURST_LOG2(2)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len_m1 (req_len_m1),
        .wdata      (wdata),
        .wdata_ready(wdata_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .done       (done),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous RAM: write on Write, registered read on Read
    always @(posedge Clock) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_write) ram[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Present a request and let the accepting edge pass; req_valid left low after.
    task automatic issue(input logic we, input logic [8:0] a, input logic [1:0] len);
        req_valid = 1'b1; req_we = we; req_addr = a; req_len_m1 = len;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        Clear = 1'b1;
        tick(); tick();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%0b exp=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%0b exp=0", mem_write); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_rdata_valid got=%0b exp=0", rdata_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
        checks++; if (mem_addr !== 9'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        Clear = 1'b0;
        tick();
    endtask

    task automatic test_single_load();
        preload(9'h054, 32'h0000_0097);
        issue(1'b0, 9'h054, 2'd0);
        checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL ld_issue_read got=%0b exp=1", mem_read); end
        checks++; if (mem_addr !== 9'h054) begin failures++; $display("FAIL ld_issue_addr got=%0h exp=54", mem_addr); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL ld_busy_ready got=%0b exp=0", req_ready); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL ld_issue_write got=%0b exp=0", mem_write); end
        tick();
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL ld_cap_read got=%0b exp=0", mem_read); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL ld_cap_valid got=%0b exp=0", rdata_valid); end
        tick();
        checks++; if (rdata_valid !== 1'b1) begin failures++; $display("FAIL ld_valid got=%0b exp=1", rdata_valid); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ld_done got=%0b exp=1", done); end
        checks++; if (rdata !== 32'h0000_0097) begin failures++; $display("FAIL ld_rdata got=%0h exp=97", rdata); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ld_done_ready got=%0b exp=1", req_ready); end
        tick();
        checks++; if (rdata_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ld_pulse_end got=%0b%0b exp=00", rdata_valid, done); end
        checks++; if (rdata !== 32'h0000_0097) begin failures++; $display("FAIL ld_rdata_hold got=%0h exp=97", rdata); end
    endtask

    task automatic test_store_then_load();
        preload(9'h034, 32'h0000_0025);
        wdata = 32'h1234_5678;
        issue(1'b1, 9'h034, 2'd0);
        checks++; if (mem_write !== 1'b1 || wdata_ready !== 1'b1) begin failures++; $display("FAIL st_write got=%0b%0b exp=11", mem_write, wdata_ready); end
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL st_read got=%0b exp=0", mem_read); end
        checks++; if (mem_addr !== 9'h034) begin failures++; $display("FAIL st_addr got=%0h exp=34", mem_addr); end
        checks++; if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL st_wdata got=%0h exp=12345678", mem_wdata); end
        tick();
        checks++; if (done !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL st_done got=%0b%0b exp=10", done, mem_write); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL st_no_rvalid got=%0b exp=0", rdata_valid); end
        checks++; if (ram[9'h034] !== 32'h1234_5678) begin failures++; $display("FAIL st_ram got=%0h exp=12345678", ram[9'h034]); end
        issue(1'b0, 9'h034, 2'd0);
        tick(); tick();
        checks++; if (rdata !== 32'h1234_5678 || rdata_valid !== 1'b1) begin failures++; $display("FAIL raw_rdata got=%0h/%0b exp=12345678/1", rdata, rdata_valid); end
        tick();
    endtask

    task automatic test_burst_store();
        logic [8:0]  ea [4];
        logic [31:0] ed [4];
        int          wr_pulses;
        ea = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        ed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        wr_pulses = 0;
        wdata = ed[0];
        issue(1'b1, 9'h1FE, 2'd3);
        for (int i = 0; i < 4; i++) begin
            wdata = ed[i];
            if (wdata_ready === 1'b1) wr_pulses++;
            checks++; if (mem_addr !== ea[i] || mem_write !== 1'b1) begin failures++; $display("FAIL bst_word%0d got=%0h/%0b exp=%0h/1", i, mem_addr, mem_write, ea[i]); end
            checks++; if (done !== 1'b0 || rdata_valid !== 1'b0) begin failures++; $display("FAIL bst_early_done%0d got=%0b%0b exp=00", i, done, rdata_valid); end
            tick();
        end
        checks++; if (wr_pulses != 4) begin failures++; $display("FAIL bst_wready_count got=%0d exp=4", wr_pulses); end
        checks++; if (done !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL bst_done got=%0b%0b exp=10", done, mem_write); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ram[ea[i]] !== ed[i]) begin failures++; $display("FAIL bst_ram%0d got=%0h exp=%0h", i, ram[ea[i]], ed[i]); end
        end
        tick();
    endtask

    task automatic test_burst_load();
        logic [8:0]  ea [4];
        logic [31:0] ed [4];
        ea = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        ed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        issue(1'b0, 9'h1FE, 2'd3);
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_read !== 1'b1 || mem_addr !== ea[i]) begin failures++; $display("FAIL bld_issue%0d got=%0b/%0h exp=1/%0h", i, mem_read, mem_addr, ea[i]); end
            tick();
            checks++; if (mem_read !== 1'b0 || rdata_valid !== 1'b0) begin failures++; $display("FAIL bld_cap%0d got=%0b%0b exp=00", i, mem_read, rdata_valid); end
            tick();
            checks++; if (rdata_valid !== 1'b1 || rdata !== ed[i]) begin failures++; $display("FAIL bld_data%0d got=%0b/%0h exp=1/%0h", i, rdata_valid, rdata, ed[i]); end
            checks++; if (done !== (i == 3)) begin failures++; $display("FAIL bld_done%0d got=%0b exp=%0b", i, done, (i == 3)); end
        end
        tick();
        checks++; if (rdata_valid !== 1'b0 || rdata !== 32'hDDDD_0004) begin failures++; $display("FAIL bld_after got=%0b/%0h exp=0/dddd0004", rdata_valid, rdata); end
    endtask

    task automatic test_clear_mid_store();
        preload(9'h100, 32'h5555_0000);
        preload(9'h101, 32'h5555_0001);
        preload(9'h102, 32'h5555_0002);
        preload(9'h103, 32'h5555_0003);
        wdata = 32'hC1EA_0000;
        issue(1'b1, 9'h100, 2'd3);
        tick();
        wdata = 32'hC1EA_0001;
        checks++; if (mem_write !== 1'b1 || mem_addr !== 9'h101) begin failures++; $display("FAIL clr_pre got=%0b/%0h exp=1/101", mem_write, mem_addr); end
        #2;
        Clear = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0 || wdata_ready !== 1'b0) begin failures++; $display("FAIL clr_write_drop got=%0b%0b exp=00", mem_write, wdata_ready); end
        checks++; if (req_ready !== 1'b1 || mem_addr !== 9'h0) begin failures++; $display("FAIL clr_idle got=%0b/%0h exp=1/0", req_ready, mem_addr); end
        tick();
        Clear = 1'b0;
        tick();
        checks++; if (ram[9'h100] !== 32'hC1EA_0000) begin failures++; $display("FAIL clr_ram0 got=%0h exp=c1ea0000", ram[9'h100]); end
        checks++; if (ram[9'h101] !== 32'h5555_0001) begin failures++; $display("FAIL clr_ram1 got=%0h exp=55550001", ram[9'h101]); end
        checks++; if (ram[9'h102] !== 32'h5555_0002 || ram[9'h103] !== 32'h5555_0003) begin failures++; $display("FAIL clr_ram23 got=%0h/%0h exp=55550002/55550003", ram[9'h102], ram[9'h103]); end
        checks++; if (req_ready !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL clr_after got=%0b%0b exp=10", req_ready, mem_write); end
    endtask

    task automatic test_back_to_back();
        wdata = 32'hB2B0_0000;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_len_m1 = 2'd1;
        tick();
        // keep req_valid high with the next (load) request while the store runs
        req_we = 1'b0; req_addr = 9'h020; req_len_m1 = 2'd0;
        checks++; if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 9'h020) begin failures++; $display("FAIL b2b_w0 got=%0b%0b/%0h exp=01/20", req_ready, mem_write, mem_addr); end
        tick();
        wdata = 32'hB2B0_0001;
        checks++; if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 9'h021) begin failures++; $display("FAIL b2b_w1 got=%0b%0b/%0h exp=01/21", req_ready, mem_write, mem_addr); end
        tick();
        checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b%0b exp=11", done, req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 9'h020) begin failures++; $display("FAIL b2b_no_gap got=%0b/%0h exp=1/20", mem_read, mem_addr); end
        tick(); tick();
        checks++; if (rdata_valid !== 1'b1 || done !== 1'b1 || rdata !== 32'hB2B0_0000) begin failures++; $display("FAIL b2b_load got=%0b%0b/%0h exp=11/b2b00000", rdata_valid, done, rdata); end
        checks++; if (ram[9'h021] !== 32'hB2B0_0001) begin failures++; $display("FAIL b2b_ram1 got=%0h exp=b2b00001", ram[9'h021]); end
        tick();
    endtask

    initial begin
        Clear = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len_m1 = '0;
        wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        test_reset();
        test_single_load();
        test_store_then_load();
        test_burst_store();
        test_burst_load();
        test_clear_mid_store();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
